// File: rtl/alu_arb.sv
// Round-robin arbiter that shares one alu_math datapath among NREQ requesters.
// Issues one command at a time, waits for alu_ready (with a watchdog), and routes the result back.
module alu_arb #(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 64,
    parameter int CW      = 7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req,
    input  logic [8*NREQ-1:0] req_dat,
    output logic [NREQ-1:0]   gnt,
    output logic              alu_ctl,
    output logic [7:0]        alu_dat,
    input  logic              alu_ready,
    input  logic [31:0]       alu_result,
    output logic [NREQ-1:0]   rsp_val,
    output logic [31:0]       rsp_data,
    output logic              rsp_err,
    output logic              busy
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t        state;
    logic [PW-1:0] ptr;
    logic [PW-1:0] win;
    logic [CW-1:0] cnt;
    logic [PW-1:0] pick;
    logic [7:0]    pick_dat;

    // First set request at or above p, wrapping; the doubled vector makes the wrap a plain shift.
    function automatic logic [PW-1:0] rr_pick(input logic [NREQ-1:0] r, input logic [PW-1:0] p);
        logic [2*NREQ-1:0] dbl;
        logic [PW-1:0]     sel;
        logic              found;
        int                idx;
        dbl   = {r, r} >> p;
        sel   = '0;
        found = 1'b0;
        for (int j = 0; j < NREQ; j++) begin
            if (!found && dbl[j]) begin
                idx = int'(p) + j;
                if (idx >= NREQ) idx = idx - NREQ;
                sel   = PW'(idx);
                found = 1'b1;
            end
        end
        return sel;
    endfunction

    function automatic logic [7:0] byte_of(input logic [8*NREQ-1:0] d, input logic [PW-1:0] i);
        logic [7:0] b;
        b = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (PW'(k) == i) b = d[8*k +: 8];
        end
        return b;
    endfunction

    function automatic logic [NREQ-1:0] onehot(input logic [PW-1:0] i);
        return NREQ'(1) << i;
    endfunction

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] i);
        return (i == PW'(NREQ - 1)) ? '0 : i + 1'b1;
    endfunction

    always_comb begin
        pick     = rr_pick(req, ptr);
        pick_dat = byte_of(req_dat, pick);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            ptr      <= '0;
            win      <= '0;
            cnt      <= '0;
            gnt      <= '0;
            alu_ctl  <= 1'b0;
            alu_dat  <= '0;
            rsp_val  <= '0;
            rsp_data <= '0;
            rsp_err  <= 1'b0;
            busy     <= 1'b0;
        end else begin
            case (state)
                // Arbitrate and sample the winner's operand so later req changes cannot affect it.
                IDLE: begin
                    if (|req) begin
                        win     <= pick;
                        alu_dat <= pick_dat;
                        gnt     <= onehot(pick);
                        alu_ctl <= 1'b1;
                        busy    <= 1'b1;
                        state   <= ISSUE;
                    end
                end
                ISSUE: begin
                    gnt     <= '0;
                    alu_ctl <= 1'b0;
                    cnt     <= '0;
                    state   <= WAIT;
                end
                // Ready takes priority over the watchdog when both land on the same cycle.
                WAIT: begin
                    cnt <= cnt + 1'b1;
                    if (alu_ready) begin
                        rsp_data <= alu_result;
                        rsp_err  <= 1'b0;
                        rsp_val  <= onehot(win);
                        state    <= RESP;
                    end else if (cnt == CW'(TIMEOUT - 1)) begin
                        rsp_data <= '0;
                        rsp_err  <= 1'b1;
                        rsp_val  <= onehot(win);
                        state    <= RESP;
                    end
                end
                RESP: begin
                    rsp_val <= '0;
                    ptr     <= next_ptr(win);
                    busy    <= 1'b0;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arb.sv
// Directed and randomized bench for alu_arb; expected grants come from a round-robin model
// kept as a plain integer pointer, expected responses from the stimulus itself.
module tb_alu_arb;

    localparam int NREQ    = 4;
    localparam int TIMEOUT = 64;
    localparam int CW      = 7;

    logic              clk = 1'b0;
    logic              rst;
    logic [NREQ-1:0]   req;
    logic [8*NREQ-1:0] req_dat;
    logic [NREQ-1:0]   gnt;
    logic              alu_ctl;
    logic [7:0]        alu_dat;
    logic              alu_ready;
    logic [31:0]       alu_result;
    logic [NREQ-1:0]   rsp_val;
    logic [31:0]       rsp_data;
    logic              rsp_err;
    logic              busy;

    int n_assert = 0;
    int n_fail   = 0;
    int m_ptr    = 0;

    alu_arb #(.NREQ(NREQ), .TIMEOUT(TIMEOUT), .CW(CW)) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .req_dat    (req_dat),
        .gnt        (gnt),
        .alu_ctl    (alu_ctl),
        .alu_dat    (alu_dat),
        .alu_ready  (alu_ready),
        .alu_result (alu_result),
        .rsp_val    (rsp_val),
        .rsp_data   (rsp_data),
        .rsp_err    (rsp_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Round-robin reference: scan upward from the model pointer, wrapping.
    function automatic int model_pick(input logic [NREQ-1:0] r);
        int rv;
        int idx;
        rv = int'(r);
        for (int k = 0; k < NREQ; k++) begin
            idx = (m_ptr + k) % NREQ;
            if (((rv >> idx) % 2) == 1) return idx;
        end
        return -1;
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, ".gnt"}, 32'(gnt), 32'd0);
        check({tag, ".alu_ctl"}, 32'(alu_ctl), 32'd0);
        check({tag, ".alu_dat"}, 32'(alu_dat), 32'd0);
        check({tag, ".rsp_val"}, 32'(rsp_val), 32'd0);
        check({tag, ".rsp_data"}, rsp_data, 32'd0);
        check({tag, ".rsp_err"}, 32'(rsp_err), 32'd0);
        check({tag, ".busy"}, 32'(busy), 32'd0);
    endtask

    // Entered at a falling edge with the DUT idle; returns at the falling edge after RESP.
    // delay: WAIT cycle index on which alu_ready is driven, or -1 for never.
    task automatic do_txn(input logic [NREQ-1:0] r, input logic [31:0] dat_all, input int delay,
                          input logic [31:0] res, input bit hold_req, input bit stray_issue,
                          input string tag);
        int          w;
        int          k;
        bit          done;
        bit          exp_err;
        logic [31:0] exp_op;
        logic [31:0] exp_data;
        req      = r;
        req_dat  = dat_all;
        w        = model_pick(r);
        exp_op   = (dat_all >> (8 * w)) & 32'hFF;
        exp_err  = (delay < 0) || (delay > TIMEOUT - 1);
        exp_data = exp_err ? 32'd0 : res;
        @(negedge clk);
        check({tag, ".gnt"}, 32'(gnt), 32'd1 << w);
        check({tag, ".alu_ctl"}, 32'(alu_ctl), 32'd1);
        check({tag, ".alu_dat"}, 32'(alu_dat), exp_op);
        check({tag, ".busy_issue"}, 32'(busy), 32'd1);
        if (!hold_req) req = '0;
        req_dat = $urandom;
        if (stray_issue) begin
            alu_ready  = 1'b1;
            alu_result = $urandom;
        end
        k    = 0;
        done = 1'b0;
        while (!done) begin
            @(negedge clk);
            check({tag, ".rsp_val_wait"}, 32'(rsp_val), 32'd0);
            if (k == 0) begin
                check({tag, ".alu_ctl_wait"}, 32'(alu_ctl), 32'd0);
                check({tag, ".gnt_wait"}, 32'(gnt), 32'd0);
            end
            if (delay == k) begin
                alu_ready  = 1'b1;
                alu_result = res;
            end else begin
                alu_ready  = 1'b0;
                alu_result = $urandom;
            end
            if (delay == k || k == TIMEOUT - 1) done = 1'b1;
            k++;
        end
        @(negedge clk);
        check({tag, ".rsp_val"}, 32'(rsp_val), 32'd1 << w);
        check({tag, ".rsp_data"}, rsp_data, exp_data);
        check({tag, ".rsp_err"}, 32'(rsp_err), 32'(exp_err));
        check({tag, ".alu_dat_hold"}, 32'(alu_dat), exp_op);
        check({tag, ".busy_resp"}, 32'(busy), 32'd1);
        alu_ready = 1'b0;
        m_ptr     = (w + 1) % NREQ;
        @(negedge clk);
        check({tag, ".rsp_val_after"}, 32'(rsp_val), 32'd0);
        check({tag, ".busy_after"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int w;
        rst        = 1'b1;
        req        = '0;
        req_dat    = '0;
        alu_ready  = 1'b0;
        alu_result = '0;

        @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;
        @(negedge clk);
        check("idle.busy", 32'(busy), 32'd0);

        // Full contention: grants must rotate 0,1,2,3,0,1,2,3.
        for (int t = 0; t < 2 * NREQ; t++) begin
            check("rr.model_order", 32'(model_pick(4'b1111)), 32'(t % NREQ));
            do_txn(4'b1111, $urandom, 0, $urandom, 1'b1, 1'b0, "rr");
        end
        req = '0;

        do_txn(4'b0100, 32'h005A_0000 | ($urandom & 32'hFF00_FFFF), 0, 32'hDEAD_0001,
               1'b0, 1'b0, "single");

        do_txn(4'b0010, $urandom, -1, $urandom, 1'b0, 1'b0, "timeout");

        do_txn(4'b0001, $urandom, TIMEOUT - 1, 32'hCAFE_F00D, 1'b0, 1'b0, "race");

        // Stray ready while idle must not start anything.
        req = '0;
        for (int t = 0; t < 3; t++) begin
            alu_ready  = 1'b1;
            alu_result = $urandom;
            @(negedge clk);
            check("stray_idle.rsp_val", 32'(rsp_val), 32'd0);
            check("stray_idle.busy", 32'(busy), 32'd0);
        end
        alu_ready = 1'b0;
        do_txn(4'b1000, $urandom, 2, 32'h1234_5678, 1'b0, 1'b1, "stray_issue");

        for (int t = 0; t < 20; t++) begin
            do_txn(NREQ'($urandom_range(1, 15)), $urandom, int'($urandom_range(0, 6)),
                   $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), "rand");
        end
        req = '0;
        @(negedge clk);

        // Reset asserted between edges while waiting for the math unit.
        req     = 4'b1000;
        req_dat = $urandom;
        w       = model_pick(4'b1000);
        @(negedge clk);
        check("midrst.gnt", 32'(gnt), 32'd1 << w);
        req = '0;
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1 check_all_zero("midrst_async");
        m_ptr = 0;
        @(negedge clk);
        rst = 1'b0;
        for (int t = 0; t < 3; t++) begin
            alu_ready = (t == 1);
            @(negedge clk);
            check("midrst.rsp_val", 32'(rsp_val), 32'd0);
            check("midrst.busy", 32'(busy), 32'd0);
        end
        alu_ready = 1'b0;
        check("midrst.model_ptr0", 32'(model_pick(4'b1001)), 32'd0);
        do_txn(4'b1001, $urandom, 0, $urandom, 1'b0, 1'b0, "post_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
